// File: rtl/dmem_lsu.sv
// Byte-addressable little-endian data memory with sized loads/stores and a fixed read latency.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors instead of aligning them.
module dmem_lsu #(
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 14,
  parameter int RD_LAT     = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  // state  | meaning
  // S_IDLE | ready for a request
  // S_WAIT | load accepted, counting down the extra read latency
  // S_RESP | response presented for one cycle
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam int         DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [1:0] CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  logic [31:0] mem_q [DEPTH];

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pend_rdata_q;
  logic        pend_err_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic                  accept;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic                  range_err, size_err, align_err, acc_err;
  logic [3:0]            be;
  logic [31:0]           wdata_lanes, rd_word, ld_data, rsp_now;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign accept    = req_valid & req_ready;

  assign idx       = req_addr[DEPTH_LOG2+1:2];
  assign lane      = req_addr[1:0];
  assign range_err = |(req_addr >> (DEPTH_LOG2 + 2));
  assign size_err  = (req_size == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign align_err = ((req_size == 2'b01) && lane[0]) || ((req_size == 2'b10) && (lane != 2'b00));
`else
  assign align_err = 1'b0;
`endif
  assign acc_err   = range_err | size_err | align_err;
  assign rsp_now   = (req_we || acc_err) ? 32'h0 : ld_data;

  // Lane enables and load extraction; without the trap, half/word ignore the low address bits.
  always_comb begin
    be          = 4'b0000;
    wdata_lanes = 32'h0;
    ld_data     = 32'h0;
    ld_byte     = 8'h0;
    ld_half     = 16'h0;
    rd_word     = mem_q[idx];
    case (req_size)
      2'b00: begin
        be          = 4'b0001 << lane;
        wdata_lanes = {4{req_wdata[7:0]}};
        ld_byte     = rd_word[{lane, 3'b000} +: 8];
        ld_data     = {{24{~req_unsigned & ld_byte[7]}}, ld_byte};
      end
      2'b01: begin
        be          = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{req_wdata[15:0]}};
        ld_half     = lane[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data     = {{16{~req_unsigned & ld_half[15]}}, ld_half};
      end
      2'b10: begin
        be          = 4'b1111;
        wdata_lanes = req_wdata;
        ld_data     = rd_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (accept && req_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_we || RD_LAT == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result is captured at accept but only driven out on entry to RESP so outputs hold between responses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      pend_rdata_q <= 32'h0;
      pend_err_q   <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        pend_rdata_q <= rsp_now;
        pend_err_q   <= acc_err;
      end
      if (state_d == S_RESP) begin
        if (state_q == S_IDLE) begin
          rsp_rdata_q <= rsp_now;
          rsp_err_q   <= acc_err;
        end else begin
          rsp_rdata_q <= pend_rdata_q;
          rsp_err_q   <= pend_err_q;
        end
      end
    end
  end

endmodule
